maze_generator: RTL

Randomized depth-first maze carver that produces the 16×16 `path_data` bitmap consumed by the VGA maze renderer.
- On `start` it samples the maze dimensions and a seed, then clears the bitmap.
- It carves a perfect maze (spanning tree) over even-coordinate cells, using an LFSR for direction choice and an on-chip cell stack for backtracking.
- It sits between game control logic (which issues `start` and seed) and the renderer (which reads `path_data`, bit index `x + 16*y`, 1 = path).

---
 rtl/maze_pkg.sv | 29 ++
 rtl/maze_lfsr.sv | 28 ++
 rtl/maze_generator.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared constants, FSM state encoding and helpers for the maze carver.
package maze_pkg;
  localparam int GRID_DIM = 16;
  localparam int STACK_DEPTH = 64;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  // Taps for x^16+x^14+x^13+x^11+1 on a left-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [1:0] DIR_PX = 2'd0;
  localparam logic [1:0] DIR_PY = 2'd1;
  localparam logic [1:0] DIR_NX = 2'd2;
  localparam logic [1:0] DIR_NY = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    INIT,
    PICK,
    CARVE,
    POP,
    DONE
  } maze_gen_state_t;

  function automatic logic [4:0] clamp_dim(input logic [4:0] v);
    if (v == 5'd0) return 5'd1;
    if (v > 5'd16) return 5'd16;
    return v;
  endfunction
endpackage

// File: rtl/maze_lfsr.sv
// 16-bit Fibonacci LFSR with synchronous load and a one-shot step; a zero seed
// is replaced by the default so the register can never lock up.
module maze_lfsr (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  input  logic        i_step,
  output logic [15:0] o_value
);
  import maze_pkg::*;

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb    = ^(r_lfsr & LFSR_TAPS);
  assign o_value = r_lfsr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lfsr <= LFSR_DEFAULT_SEED;
    end else if (i_load) begin
      r_lfsr <= (i_seed == 16'd0) ? LFSR_DEFAULT_SEED : i_seed;
    end else if (i_step) begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end
endmodule

// File: rtl/maze_generator.sv
// Depth-first maze carver producing a 16x16 path bitmap (bit x+16*y, 1 = path).
// Define MAZE_GEN_ANIMATE_EN to expose the working bitmap instead of a shadow copy.
module maze_generator #(
  parameter int GRID_DIM    = 16,
  parameter int STACK_DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [15:0]                  seed,
  input  logic [4:0]                   maze_width,
  input  logic [4:0]                   maze_height,
  output logic [GRID_DIM*GRID_DIM-1:0] path_data,
  output logic                         busy,
  output logic                         done
);
  import maze_pkg::*;

  maze_gen_state_t r_state, w_next;

  logic [4:0]   r_w, r_h;
  logic [15:0]  r_seed;
  logic [2:0]   r_ci, r_cj;
  logic [1:0]   r_dir;
  logic [6:0]   r_sp;
  logic [5:0]   r_stack [STACK_DEPTH];
  logic [GRID_DIM*GRID_DIM-1:0] r_map;

  logic [15:0]  w_lfsr;
  logic [13:0]  w_unused_lfsr;
  logic [3:0]   w_xt, w_yt;
  logic [3:0]   w_mask;
  logic [7:0]   w_rot;
  logic [1:0]   w_pick, w_dir;
  logic [2:0]   w_ni, w_nj;
  logic [3:0]   w_wall_x, w_wall_y;
  logic [6:0]   w_sp_dec;

  maze_lfsr u_lfsr (
    .i_clk   (clk),
    .i_reset (reset),
    .i_load  (r_state == CLEAR),
    .i_seed  (r_seed),
    .i_step  (r_state == CARVE),
    .o_value (w_lfsr)
  );

  assign w_unused_lfsr = w_lfsr[15:2];
  assign w_xt          = {r_ci, 1'b0};
  assign w_yt          = {r_cj, 1'b0};
  assign w_sp_dec      = r_sp - 7'd1;
  assign w_wall_x      = {1'b0, r_ci} + {1'b0, w_ni};
  assign w_wall_y      = {1'b0, r_cj} + {1'b0, w_nj};

  always_comb begin
    w_mask         = '0;
    w_mask[DIR_PX] = (({1'b0, w_xt} + 5'd2) < r_w) && !r_map[{w_yt, w_xt + 4'd2}];
    w_mask[DIR_PY] = (({1'b0, w_yt} + 5'd2) < r_h) && !r_map[{w_yt + 4'd2, w_xt}];
    w_mask[DIR_NX] = (r_ci != 3'd0) && !r_map[{w_yt, w_xt - 4'd2}];
    w_mask[DIR_NY] = (r_cj != 3'd0) && !r_map[{w_yt - 4'd2, w_xt}];
  end

  // Rotating the mask by d0 turns "first set in order d0..d0+3" into a plain priority pick.
  always_comb begin
    w_rot = {w_mask, w_mask} >> w_lfsr[1:0];
    if (w_rot[0])      w_pick = 2'd0;
    else if (w_rot[1]) w_pick = 2'd1;
    else if (w_rot[2]) w_pick = 2'd2;
    else               w_pick = 2'd3;
    w_dir = w_lfsr[1:0] + w_pick;
  end

  always_comb begin
    w_ni = r_ci;
    w_nj = r_cj;
    case (r_dir)
      DIR_PX:  w_ni = r_ci + 3'd1;
      DIR_PY:  w_nj = r_cj + 3'd1;
      DIR_NX:  w_ni = r_ci - 3'd1;
      default: w_nj = r_cj - 3'd1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CLEAR;
      CLEAR:   w_next = INIT;
      INIT:    w_next = PICK;
      PICK:    w_next = (w_mask == 4'd0) ? POP : CARVE;
      CARVE:   w_next = PICK;
      POP:     w_next = (w_sp_dec == 7'd0) ? DONE : PICK;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
    done = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_map  <= '0;
      r_sp   <= '0;
      r_ci   <= '0;
      r_cj   <= '0;
      r_dir  <= '0;
      r_w    <= 5'd1;
      r_h    <= 5'd1;
      r_seed <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_w    <= clamp_dim(maze_width);
          r_h    <= clamp_dim(maze_height);
          r_seed <= seed;
        end
        CLEAR: r_map <= '0;
        INIT: begin
          r_map[0] <= 1'b1;
          r_sp     <= 7'd1;
          r_ci     <= '0;
          r_cj     <= '0;
        end
        PICK: r_dir <= w_dir;
        CARVE: begin
          r_map[{w_wall_y, w_wall_x}]           <= 1'b1;
          r_map[{w_nj, 1'b0, w_ni, 1'b0}]       <= 1'b1;
          r_sp                                  <= r_sp + 7'd1;
          r_ci                                  <= w_ni;
          r_cj                                  <= w_nj;
        end
        POP: begin
          r_sp <= w_sp_dec;
          if (w_sp_dec != 7'd0) {r_cj, r_ci} <= r_stack[w_sp_dec[5:0] - 6'd1];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == INIT)       r_stack[0]          <= 6'd0;
    else if (r_state == CARVE) r_stack[r_sp[5:0]]  <= {w_nj, w_ni};
  end

`ifdef MAZE_GEN_ANIMATE_EN
  assign path_data = r_map;
`else
  logic [GRID_DIM*GRID_DIM-1:0] r_path;

  // Load on the final POP so the new maze appears together with done.
  always_ff @(posedge clk) begin
    if (reset)                                   r_path <= '0;
    else if (r_state == POP && w_sp_dec == 7'd0) r_path <= r_map;
  end

  assign path_data = r_path;
`endif
endmodule
